// File: rtl/fifo_rr_sched.sv
// Round-robin scheduler that drains NREQ upstream FIFOs into one valid/ready channel.
// Each grant moves up to BURST words and costs one idle arbitration cycle.
module fifo_rr_sched #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned BURST = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_val,
    input  logic [NREQ*WIDTH-1:0]     req_dat,
    output logic [NREQ-1:0]           req_pop,
    input  logic [NREQ-1:0]           req_en,
    output logic                      out_val,
    output logic [WIDTH-1:0]          out_dat,
    output logic [$clog2(NREQ)-1:0]   out_src,
    input  logic                      out_rdy,
    output logic                      busy
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned BW = $clog2(BURST) + 1;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    logic          state_q, state_d;
    logic [IW-1:0] gnt_q, gnt_d;
    logic [IW-1:0] last_q, last_d;
    logic [BW-1:0] beat_q, beat_d;

    logic [NREQ-1:0]  elig;
    logic             sel_found;
    logic [IW-1:0]    sel_idx;
    logic [IW-1:0]    cand;
    logic [WIDTH-1:0] dat_arr [NREQ];

    // Unpack the flat head-word bus so the granted word can be indexed directly.
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign dat_arr[i] = req_dat[i*WIDTH +: WIDTH];
    end

    assign elig = req_val & req_en;

    // Pick the first eligible requester after the most recent grant, wrapping at NREQ.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = last_q;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = (cand == IW'(NREQ - 1)) ? '0 : cand + IW'(1);
            if (!sel_found && elig[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Output channel and pop strobe; out_val deliberately ignores out_rdy.
    always_comb begin
        out_val = 1'b0;
        out_dat = '0;
        out_src = '0;
        busy    = 1'b0;
        req_pop = '0;
        if (state_q == ST_GRANT) begin
            busy             = 1'b1;
            out_src          = gnt_q;
            out_val          = req_val[gnt_q];
            out_dat          = dat_arr[gnt_q];
            req_pop[gnt_q]   = req_val[gnt_q] & out_rdy;
        end
    end

    // Next-state logic for arbitration and burst counting.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        beat_d  = beat_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    gnt_d   = sel_idx;
                    last_d  = sel_idx;
                    beat_d  = '0;
                    state_d = ST_GRANT;
                end
            end
            default: begin
                if (!req_val[gnt_q]) begin
                    // FIFO drained before the burst finished: give up the grant early.
                    state_d = ST_IDLE;
                    beat_d  = '0;
                end else if (out_rdy) begin
                    if (beat_q == BW'(BURST - 1)) begin
                        state_d = ST_IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
        endcase
    end

    // State registers with synchronous reset; last starts at NREQ-1 so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            last_q  <= IW'(NREQ - 1);
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end

endmodule

// File: tb/tb_fifo_rr_sched.sv
// Directed bench for fifo_rr_sched: behavioural source FIFOs, handshake log, fixed expectations.
module tb_fifo_rr_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int BURST = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_val;
    logic [31:0] req_dat;
    logic [3:0]  req_pop;
    logic [3:0]  req_en;
    logic        out_val;
    logic [7:0]  out_dat;
    logic [1:0]  out_src;
    logic        out_rdy;
    logic        busy;

    logic [7:0] mem [4][32];
    int         rd  [4];
    int         wr  [4];
    int         cyc;
    int         log_q [$];
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    fifo_rr_sched #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH),
        .BURST (BURST)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req_val (req_val),
        .req_dat (req_dat),
        .req_pop (req_pop),
        .req_en  (req_en),
        .out_val (out_val),
        .out_dat (out_dat),
        .out_src (out_src),
        .out_rdy (out_rdy),
        .busy    (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < 4; i++) begin
            req_val[i]       = (rd[i] != wr[i]);
            req_dat[i*8 +: 8] = (rd[i] != wr[i]) ? mem[i][rd[i][4:0]] : 8'h00;
        end
    endtask

    task automatic clear_fifos();
        for (int i = 0; i < 4; i++) begin
            rd[i] = 0;
            wr[i] = 0;
        end
        refresh();
    endtask

    task automatic load(input int s, input int n);
        for (int j = 0; j < n; j++) mem[s][j] = 8'(s * 16 + j);
        wr[s] = n;
    endtask

    // One clock: invariant checks and handshake logging at the negedge, pops applied after posedge.
    task automatic tick();
        logic [3:0] p;
        check_eq("pop_onehot", 32'($countones(req_pop) <= 1), 32'd1);
        check_eq("pop_nonempty", 32'((req_pop & ~req_val) == 4'b0), 32'd1);
        if (out_val && out_rdy)
            log_q.push_back((cyc << 16) | (int'(out_src) << 8) | int'(out_dat));
        p = req_pop;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (p[i]) rd[i]++;
        refresh();
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        tick();
        rst = 1'b0;
        clear_fifos();
    endtask

    task automatic begin_test();
        refresh();
        cyc = 0;
        log_q.delete();
        #1;
    endtask

    initial begin
        int bs [5];
        int seq [4];
        int b;
        int s;
        rst     = 1'b1;
        req_en  = 4'b1111;
        out_rdy = 1'b1;
        cyc     = 0;
        clear_fifos();
        @(negedge clk);

        // Reset held two cycles with nothing valid, then a single word at FIFO0.
        for (int i = 0; i < 2; i++) begin
            check_eq("rst_out_val", 32'(out_val), 32'd0);
            check_eq("rst_busy", 32'(busy), 32'd0);
            check_eq("rst_pop", 32'(req_pop), 32'd0);
            check_eq("rst_src_dat", {22'd0, out_src, out_dat}, 32'd0);
            tick();
        end
        rst = 1'b0;
        mem[0][0] = 8'h5A;
        wr[0] = 1;
        begin_test();
        check_eq("rel_busy_c0", 32'(busy), 32'd0);
        tick();
        check_eq("rel_busy_c1", 32'(busy), 32'd1);
        check_eq("rel_src_c1", 32'(out_src), 32'd0);
        check_eq("rel_dat_c1", 32'(out_dat), 32'h5A);
        tick();
        tick();
        check_eq("rel_idle", 32'(busy), 32'd0);

        // Round robin across four full FIFOs.
        do_reset();
        for (int i = 0; i < 4; i++) load(i, 8);
        begin_test();
        repeat (45) tick();
        check_eq("rr_count", 32'(log_q.size()), 32'd32);
        for (int k = 0; k < 32 && k < log_q.size(); k++) begin
            b = k / 4;
            s = b % 4;
            check_eq("rr_word", 32'(log_q[k]),
                     32'(((b * 5 + 1 + k % 4) << 16) | (s << 8) | (s * 16 + (b / 4) * 4 + k % 4)));
        end
        check_eq("rr_end_busy", 32'(busy), 32'd0);

        // Short drain: FIFO1 holds two words only.
        do_reset();
        mem[1][0] = 8'hA0;
        mem[1][1] = 8'hA1;
        wr[1] = 2;
        begin_test();
        check_eq("sd_busy_c0", 32'(busy), 32'd0);
        tick();
        check_eq("sd_c1", {22'd0, out_src, out_dat}, {22'd0, 2'd1, 8'hA0});
        check_eq("sd_pop_c1", 32'(req_pop), 32'b0010);
        tick();
        check_eq("sd_c2", {22'd0, out_src, out_dat}, {22'd0, 2'd1, 8'hA1});
        check_eq("sd_pop_c2", 32'(req_pop), 32'b0010);
        tick();
        check_eq("sd_val_c3", 32'(out_val), 32'd0);
        check_eq("sd_pop_c3", 32'(req_pop), 32'd0);
        tick();
        check_eq("sd_busy_c4", 32'(busy), 32'd0);

        // Backpressure for three cycles after the first beat.
        do_reset();
        load(0, 4);
        begin_test();
        tick();
        tick();
        out_rdy = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq("bp_val", 32'(out_val), 32'd1);
            check_eq("bp_dat", 32'(out_dat), 32'h01);
            check_eq("bp_pop", 32'(req_pop), 32'd0);
            tick();
        end
        out_rdy = 1'b1;
        #1;
        tick();
        tick();
        check_eq("bp_busy_c7", 32'(busy), 32'd1);
        tick();
        check_eq("bp_busy_c8", 32'(busy), 32'd0);
        check_eq("bp_count", 32'(log_q.size()), 32'd4);
        if (log_q.size() == 4) begin
            check_eq("bp_w0", 32'(log_q[0]), (32'd1 << 16) | 32'h00);
            check_eq("bp_w1", 32'(log_q[1]), (32'd5 << 16) | 32'h01);
            check_eq("bp_w2", 32'(log_q[2]), (32'd6 << 16) | 32'h02);
            check_eq("bp_w3", 32'(log_q[3]), (32'd7 << 16) | 32'h03);
        end

        // Enable mask 1011, then requester 0 disabled mid-burst.
        do_reset();
        req_en = 4'b1011;
        for (int i = 0; i < 4; i++) load(i, 8);
        begin_test();
        tick();
        tick();
        req_en = 4'b1010;
        #1;
        repeat (40) tick();
        bs = '{0, 1, 3, 1, 3};
        seq = '{0, 0, 0, 0};
        check_eq("en_count", 32'(log_q.size()), 32'd20);
        for (int k = 0; k < 20 && k < log_q.size(); k++) begin
            b = k / 4;
            s = bs[b];
            check_eq("en_word", 32'(log_q[k]),
                     32'(((b * 5 + 1 + k % 4) << 16) | (s << 8) | (s * 16 + seq[s])));
            seq[s]++;
        end
        req_en = 4'b1111;

        // Reset in the middle of requester 1's burst.
        do_reset();
        load(0, 8);
        load(1, 8);
        begin_test();
        repeat (8) tick();
        check_eq("mr_src_c8", 32'(out_src), 32'd1);
        rst = 1'b1;
        #1;
        tick();
        check_eq("mr_busy", 32'(busy), 32'd0);
        check_eq("mr_pop", 32'(req_pop), 32'd0);
        check_eq("mr_val", 32'(out_val), 32'd0);
        rst = 1'b0;
        #1;
        tick();
        check_eq("mr_regrant", {22'd0, busy, out_src, out_dat[6:0]}, {22'd0, 1'b1, 2'd0, 7'h04});
        check_eq("mr_dat", 32'(out_dat), 32'h04);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
